seq_match_monitor: RTL and testbench

- Downstream consumer of the Moore 1010 sequence detector's match output z.
- Counts detections over programmable back-to-back windows of N clock cycles and reports each window's count.
- Raises an alarm when a window's count reaches a threshold, and keeps a saturating lifetime total.
- Feeds status/interrupt logic; sits directly on the detector's z line in the same clock domain.

---
 rtl/seq_det_pkg.sv | 23 ++
 rtl/rise_edge_det.sv | 19 +
 rtl/seq_match_monitor.sv | 125 ++++++++++++
 tb/tb_seq_match_monitor.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared definitions for the sequence-detector monitor: FSM encoding,
// default widths and a saturating increment helper.
package seq_det_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam int CNT_W_DEF = 8;
   localparam int WIN_W_DEF = 16;
   localparam int TOT_W_DEF = 16;

   // Adds inc to v, holding at the all-ones value of a w-bit counter (w <= 32).
   function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic inc,
                                           input int unsigned w);
      logic [31:0] max_v;
      max_v = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
      if (inc && (v != max_v)) return v + 32'd1;
      return v;
   endfunction

endpackage

// File: rtl/rise_edge_det.sv
// Rising-edge detector: registers din every cycle and flags a 0->1 transition
// combinationally in the cycle the new value is presented.
module rise_edge_det (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic rise
);

   logic din_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) din_d <= 1'b0;
      else       din_d <= din;
   end

   assign rise = din & ~din_d;

endmodule

// File: rtl/seq_match_monitor.sv
// Windowed match counter on the 1010 detector's z line: per-window count,
// threshold alarm and a saturating lifetime total.
module seq_match_monitor
   import seq_det_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF,
   parameter int WIN_W = WIN_W_DEF,
   parameter int TOT_W = TOT_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             en,
   input  logic             z,
   input  logic [WIN_W-1:0] win_len,
   input  logic [CNT_W-1:0] threshold,
   output logic [CNT_W-1:0] win_count,
   output logic             win_done,
   output logic             alarm,
   output logic [TOT_W-1:0] total,
   output logic             busy
);

   localparam logic [WIN_W-1:0] ONE_W = WIN_W'(1);

   state_t           state, state_nx;
   logic [WIN_W-1:0] timer, timer_nx, len, len_nx, len_in;
   logic [CNT_W-1:0] acc, acc_nx, thr, thr_nx, final_cnt;
   logic [CNT_W-1:0] win_count_nx;
   logic             win_done_nx, alarm_nx;
   logic [TOT_W-1:0] total_nx;
   logic             ev;

   rise_edge_det u_edge (
      .clk   (clk),
      .reset (reset),
      .din   (z),
      .rise  (ev)
   );

   assign len_in    = (win_len == '0) ? ONE_W : win_len;
   assign final_cnt = CNT_W'(sat_inc(32'(acc), ev, CNT_W));
   assign busy      = (state == RUN);

   always_comb begin
      state_nx     = state;
      timer_nx     = timer;
      acc_nx       = acc;
      len_nx       = len;
      thr_nx       = thr;
      win_count_nx = win_count;
      alarm_nx     = alarm;
      win_done_nx  = 1'b0;
      total_nx     = total;

      if (clr) begin
         state_nx = IDLE;
         timer_nx = '0;
         acc_nx   = '0;
         total_nx = '0;
      end else begin
         case (state)
            IDLE: begin
               if (en) begin
                  state_nx = RUN;
                  len_nx   = len_in;
                  thr_nx   = threshold;
                  timer_nx = '0;
                  // The start cycle's event belongs to the new window.
                  acc_nx   = CNT_W'(ev);
               end
            end
            RUN: begin
               total_nx = TOT_W'(sat_inc(32'(total), ev, TOT_W));
               acc_nx   = final_cnt;
               if (timer == len - ONE_W) begin
                  win_count_nx = final_cnt;
                  alarm_nx     = (final_cnt >= thr);
                  win_done_nx  = 1'b1;
                  timer_nx     = '0;
                  acc_nx       = '0;
                  if (en) begin
                     len_nx = len_in;
                     thr_nx = threshold;
                  end else begin
                     state_nx = IDLE;
                  end
               end else if (!en) begin
                  // Abort: partial window is discarded, last results stay.
                  state_nx = IDLE;
                  acc_nx   = '0;
               end else begin
                  timer_nx = timer + ONE_W;
               end
            end
            default: state_nx = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         timer     <= '0;
         acc       <= '0;
         len       <= ONE_W;
         thr       <= '0;
         win_count <= '0;
         alarm     <= 1'b0;
         win_done  <= 1'b0;
         total     <= '0;
      end else begin
         state     <= state_nx;
         timer     <= timer_nx;
         acc       <= acc_nx;
         len       <= len_nx;
         thr       <= thr_nx;
         win_count <= win_count_nx;
         alarm     <= alarm_nx;
         win_done  <= win_done_nx;
         total     <= total_nx;
      end
   end

endmodule

// File: tb/tb_seq_match_monitor.sv
// Directed bench for seq_match_monitor: vector table for the main instance,
// plus hand sequences for count saturation (CNT_W=2) and async reset.
module tb_seq_match_monitor;

   logic        clk = 1'b0;
   logic        reset;
   logic        clr, en, z;
   logic [15:0] win_len;
   logic [7:0]  threshold;
   logic [7:0]  win_count;
   logic        win_done, alarm, busy;
   logic [15:0] total;

   logic        s_clr, s_en, s_z;
   logic [15:0] s_len;
   logic [1:0]  s_thr, s_count;
   logic        s_done, s_alarm, s_busy;
   logic [15:0] s_total;

   int checks = 0;
   int errors = 0;
   logic [7:0] exp_q[$];

   typedef struct {
      logic        en, z, clr;
      logic [15:0] len;
      logic [7:0]  thr;
      logic        e_done;
      logic [7:0]  e_cnt;
      logic        e_alarm;
      logic [15:0] e_total;
      logic        e_busy;
   } vec_t;
   vec_t vecs[$];

   seq_match_monitor dut (
      .clk(clk), .reset(reset), .clr(clr), .en(en), .z(z),
      .win_len(win_len), .threshold(threshold),
      .win_count(win_count), .win_done(win_done), .alarm(alarm),
      .total(total), .busy(busy)
   );

   seq_match_monitor #(.CNT_W(2)) dut_sat (
      .clk(clk), .reset(reset), .clr(s_clr), .en(s_en), .z(s_z),
      .win_len(s_len), .threshold(s_thr),
      .win_count(s_count), .win_done(s_done), .alarm(s_alarm),
      .total(s_total), .busy(s_busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic add(input int a_en, a_z, a_clr, a_len, a_thr,
                      input int d, c, a, t, b);
      vec_t v;
      v.en = 1'(a_en); v.z = 1'(a_z); v.clr = 1'(a_clr);
      v.len = 16'(a_len); v.thr = 8'(a_thr);
      v.e_done = 1'(d); v.e_cnt = 8'(c); v.e_alarm = 1'(a);
      v.e_total = 16'(t); v.e_busy = 1'(b);
      vecs.push_back(v);
   endtask

   // Scoreboard: every win_done pulse of the main instance pops one expected count.
   always @(negedge clk) begin
      if (reset === 1'b0 && win_done === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_extra_done actual=%0h required=none", win_count);
         end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            check("sb_win_count", win_count, e);
         end
      end
   end

   initial begin
      reset = 1'b1; clr = 0; en = 0; z = 0; win_len = 16'd8; threshold = 8'd3;
      s_clr = 0; s_en = 0; s_z = 0; s_len = 16'd16; s_thr = 2'd3;

      // en, z, clr, len, thr | done, count, alarm, total, busy
      // basic window len=8 thr=3, matches at cycles 1,3,5
      add(1,0,0,8,3, 0,0,0,0,1);
      add(1,0,0,8,3, 0,0,0,0,1);
      add(1,1,0,8,3, 0,0,0,1,1);
      add(1,0,0,8,3, 0,0,0,1,1);
      add(1,1,0,8,3, 0,0,0,2,1);
      add(1,0,0,8,3, 0,0,0,2,1);
      add(1,1,0,8,3, 0,0,0,3,1);
      add(1,0,0,8,3, 0,0,0,3,1);
      add(1,0,0,8,3, 1,3,1,3,1);
      // clr in RUN: total cleared, results held, IDLE
      add(1,0,1,8,3, 0,3,1,0,0);
      // two gapless windows, thr=4
      add(1,0,0,8,4, 0,3,1,0,1);
      for (int w = 0; w < 2; w++) begin
         add(1,0,0,8,4, 0,3,(w == 0) ? 1 : 0,3*w,1);
         add(1,1,0,8,4, 0,3,(w == 0) ? 1 : 0,3*w+1,1);
         add(1,0,0,8,4, 0,3,(w == 0) ? 1 : 0,3*w+1,1);
         add(1,1,0,8,4, 0,3,(w == 0) ? 1 : 0,3*w+2,1);
         add(1,0,0,8,4, 0,3,(w == 0) ? 1 : 0,3*w+2,1);
         add(1,1,0,8,4, 0,3,(w == 0) ? 1 : 0,3*w+3,1);
         add(1,0,0,8,4, 0,3,(w == 0) ? 1 : 0,3*w+3,1);
         add((w == 0) ? 1 : 0,0,0,8,4, 1,3,0,3*w+3,(w == 0) ? 1 : 0);
      end
      add(0,0,0,8,4, 0,3,0,6,0);
      // abort at window cycle 5 after 2 matches
      add(0,0,1,8,4, 0,3,0,0,0);
      add(1,0,0,8,4, 0,3,0,0,1);
      add(1,0,0,8,4, 0,3,0,0,1);
      add(1,1,0,8,4, 0,3,0,1,1);
      add(1,0,0,8,4, 0,3,0,1,1);
      add(1,1,0,8,4, 0,3,0,2,1);
      add(1,0,0,8,4, 0,3,0,2,1);
      add(0,0,0,8,4, 0,3,0,2,0);
      add(0,0,0,8,4, 0,3,0,2,0);
      // win_len=0 treated as 1: done every cycle
      add(0,0,1,0,1, 0,3,0,0,0);
      add(1,0,0,0,1, 0,3,0,0,1);
      add(1,1,0,0,1, 1,1,1,1,1);
      add(1,0,0,0,1, 1,0,0,1,1);
      add(1,1,0,0,1, 1,1,1,2,1);
      add(1,0,0,0,1, 1,0,0,2,1);
      add(0,1,0,0,1, 1,1,1,3,0);
      add(0,0,0,0,1, 0,1,1,3,0);
      // mid-window len/thr change applies only at the next window
      add(0,0,1,4,2, 0,1,1,0,0);
      add(1,0,0,4,2, 0,1,1,0,1);
      add(1,1,0,2,9, 0,1,1,1,1);
      add(1,0,0,2,9, 0,1,1,1,1);
      add(1,1,0,2,9, 0,1,1,2,1);
      add(1,0,0,2,9, 1,2,1,2,1);
      add(1,0,0,2,9, 0,2,1,2,1);
      add(0,0,0,2,9, 1,0,0,2,0);
      add(0,0,0,2,9, 0,0,0,2,0);

      exp_q = '{8'd3, 8'd3, 8'd3, 8'd1, 8'd0, 8'd1, 8'd0, 8'd1, 8'd2, 8'd0};

      repeat (2) step();
      check("rst_win_count", win_count, 0);
      check("rst_win_done", win_done, 0);
      check("rst_alarm", alarm, 0);
      check("rst_total", total, 0);
      check("rst_busy", busy, 0);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         en = vecs[i].en; z = vecs[i].z; clr = vecs[i].clr;
         win_len = vecs[i].len; threshold = vecs[i].thr;
         step();
         check($sformatf("r%0d_done", i), win_done, vecs[i].e_done);
         check($sformatf("r%0d_count", i), win_count, vecs[i].e_cnt);
         check($sformatf("r%0d_alarm", i), alarm, vecs[i].e_alarm);
         check($sformatf("r%0d_total", i), total, vecs[i].e_total);
         check($sformatf("r%0d_busy", i), busy, vecs[i].e_busy);
      end

      // 2-bit window count saturates at 3 with 8 matches in a 16-cycle window
      s_en = 1; s_len = 16'd16; s_thr = 2'd3; s_z = 0;
      step();
      check("sat_start_busy", s_busy, 1);
      for (int c = 0; c < 16; c++) begin
         s_z = ((c % 2) == 0);
         if (c == 15) s_en = 0;
         step();
      end
      check("sat_done", s_done, 1);
      check("sat_count", s_count, 3);
      check("sat_alarm", s_alarm, 1);
      check("sat_total", s_total, 8);
      check("sat_busy", s_busy, 0);
      s_z = 0;
      step();
      check("sat_done_clear", s_done, 0);

      // Async reset between edges clears outputs without a clock edge
      en = 1; z = 0; clr = 0; win_len = 16'd8; threshold = 8'd3;
      step();
      check("pre_rst_busy", busy, 1);
      #2;
      reset = 1'b1;
      #1;
      check("arst_busy", busy, 0);
      check("arst_total", total, 0);
      check("arst_done", win_done, 0);
      check("arst_sat_count", s_count, 0);
      check("arst_sat_alarm", s_alarm, 0);
      check("arst_sat_total", s_total, 0);
      repeat (2) step();
      @(negedge clk);
      reset = 1'b0;
      en = 0;

      check("sb_pending", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
